// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a shared 4:1 mux, with a one-cycle gap between owners and a hold timer
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       busy,
    output logic       expired
);
    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;
    localparam logic [7:0] LAST = 8'(MAX_HOLD - 1);
    state_t state, state_nx;
    logic [1:0] owner, owner_nx, ptr, ptr_nx, off, w;
    logic [7:0] hold, hold_nx, rr;
    logic exp_q, exp_nx;
    always_comb begin
        rr = {req, req} >> ptr;
        off = rr[0] ? 2'd0 : rr[1] ? 2'd1 : rr[2] ? 2'd2 : 2'd3;
        w = ptr + off;
        state_nx = state;
        owner_nx = owner;
        ptr_nx = ptr;
        hold_nx = hold;
        exp_nx = 1'b0;
        if (state == OWN) begin
            hold_nx = (hold == LAST) ? hold : hold + 8'd1;
            if (!req[owner]) state_nx = GAP;
            else if (hold == LAST) begin
                state_nx = GAP;
                exp_nx = 1'b1;
            end
        end else if (req != 4'b0) begin
            state_nx = OWN;
            owner_nx = w;
            ptr_nx = w + 2'd1;
            hold_nx = 8'd0;
        end else state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 2'd0;
            ptr <= 2'd0;
            hold <= 8'd0;
            exp_q <= 1'b0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            ptr <= ptr_nx;
            hold <= hold_nx;
            exp_q <= exp_nx;
        end
    end
    // selects follow the last owner so they stay stable through gaps and idle
    assign gnt = (state == OWN) ? 4'b0001 << owner : 4'b0000;
    assign {s1, s0} = owner;
    assign busy = (state == OWN);
    assign expired = exp_q;
endmodule
